// File: rtl/spi_ram_pkg.sv
// ----------------------------------------------------------------------------
// spi_ram_pkg
//   Shared definitions for the SPI-slave command-RAM front end.
//   - state_t      : controller FSM states (5)
//   - OP_*         : two-bit opcodes carried in frame bits [9:8]
//   - *_DEF        : default frame / read-data widths
//   Optional feature macro used by the importing files: SPI_RD_ORDER_CHECK_EN
// ----------------------------------------------------------------------------
package spi_ram_pkg;

   localparam int FRAME_W_DEF = 10;
   localparam int DATA_W_DEF  = 8;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CHK_CMD   = 3'd1,
      ST_WRITE     = 3'd2,
      ST_READ_ADD  = 3'd3,
      ST_READ_DATA = 3'd4
   } state_t;

endpackage

// File: rtl/spi_tx_serializer.sv
// ----------------------------------------------------------------------------
// spi_tx_serializer
//   Parallel-load, MSB-first shift register that drives MISO.
//   Ports:
//     clk      in   system/SPI clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     load_i   in   capture data_i; shifting starts on the following edge
//     abort_i  in   drop any transfer, MISO forced low (wins over load_i)
//     data_i   in   DATA_W read data to send
//     miso_o   out  serial data, low whenever not shifting
//     done_o   out  high for the cycle after the last bit has been driven;
//                   the next edge returns MISO low and ends the transfer
// ----------------------------------------------------------------------------
module spi_tx_serializer #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              abort_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              miso_o,
   output logic              done_o
);

   localparam int CW = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] sreg_q, sreg_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              miso_q, miso_d;

   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      miso_d = 1'b0;
      if (abort_i) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (load_i) begin
         sreg_d = data_i;
         cnt_d  = CW'(DATA_W);
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (cnt_q != '0) begin
            miso_d = sreg_q[DATA_W-1];
            sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
            cnt_d  = cnt_q - CW'(1);
         end else begin
            // all bits already on the wire: release MISO and finish
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         miso_q <= 1'b0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         miso_q <= miso_d;
      end
   end

   assign miso_o = miso_q;
   assign done_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/spi_ram_ctrl.sv
// ----------------------------------------------------------------------------
// spi_ram_ctrl
//   SPI-slave front end for the single-port command RAM. MOSI frames of
//   FRAME_W bits {op[1:0], payload} are assembled and strobed on rx_valid.
//   After a read-data frame the controller waits for tx_valid, then shifts
//   tx_data out on MISO through spi_tx_serializer.
//   Ports:
//     clk, rst_n          clock (rising edge) / async active-low reset
//     SS_n                slave select, active low; high aborts or ends a frame
//     MOSI / MISO         serial in (MSB first) / serial out (MSB first)
//     rx_data, rx_valid   last complete frame / one-cycle strobe
//     tx_data, tx_valid   RAM read data and its valid
//     cmd_err             sticky read-order error (0 unless macro defined)
//     dbg_state_o         current FSM state
//     dbg_rd_addr_seen_o  a read-address frame is pending its read-data frame
//   Handshake: rx_valid is a pure strobe (the RAM cannot back-pressure);
//   tx_valid is consumed only on the first edge it is seen high while a
//   read-data frame waits, and ignored at every other time.
//   Optional feature: `define SPI_RD_ORDER_CHECK_EN enables the read-order
//   check (11 without a pending read address, or 10 with one, is shifted but
//   not strobed and sets cmd_err).
// ----------------------------------------------------------------------------
module spi_ram_ctrl
   import spi_ram_pkg::*;
#(
   parameter int FRAME_W = FRAME_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               SS_n,
   input  logic               MOSI,
   output logic               MISO,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
   input  logic [DATA_W-1:0]  tx_data,
   input  logic               tx_valid,
   output logic               cmd_err,
   output logic [2:0]         dbg_state_o,
   output logic               dbg_rd_addr_seen_o
);

   localparam int              CNT_W     = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_W - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [FRAME_W-2:0] shreg_q, shreg_d;
   logic               rd_addr_seen_q, rd_addr_seen_d;
   logic [FRAME_W-1:0] rx_data_q, rx_data_d;
   logic               rx_valid_q, rx_valid_d;
   logic               tx_started_q, tx_started_d;
   logic               frame_bad_q, frame_bad_d;
   logic [FRAME_W-1:0] shift_in;
   logic               ser_load, ser_abort, ser_done;

   assign shift_in = {shreg_q, MOSI};

`ifdef SPI_RD_ORDER_CHECK_EN
   logic       cmd_err_q, cmd_err_d;
   logic [1:0] op_w;
   // shreg_q[0] holds op[1] while frame bit 8 is on MOSI
   assign op_w = {shreg_q[0], MOSI};
`endif

   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      shreg_d        = shreg_q;
      rd_addr_seen_d = rd_addr_seen_q;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      tx_started_d   = tx_started_q;
      frame_bad_d    = frame_bad_q;
      ser_load       = 1'b0;
      ser_abort      = 1'b0;
`ifdef SPI_RD_ORDER_CHECK_EN
      cmd_err_d      = cmd_err_q;
`endif
      if (state_q == ST_IDLE) begin
         bit_cnt_d    = '0;
         tx_started_d = 1'b0;
         frame_bad_d  = 1'b0;
         if (!SS_n) state_d = ST_CHK_CMD;
      end else if (SS_n) begin
         // abort: partial frame dropped, rd_addr_seen deliberately kept
         state_d      = ST_IDLE;
         bit_cnt_d    = '0;
         ser_abort    = 1'b1;
         tx_started_d = 1'b0;
         frame_bad_d  = 1'b0;
      end else if (state_q == ST_CHK_CMD) begin
         shreg_d     = shift_in[FRAME_W-2:0];
         bit_cnt_d   = CNT_W'(1);
         frame_bad_d = 1'b0;
         if (!MOSI) begin
            state_d = ST_WRITE;
         end else begin
`ifdef SPI_RD_ORDER_CHECK_EN
            // tentative; the real read state is picked once op[0] arrives
            state_d = ST_READ_ADD;
`else
            state_d = rd_addr_seen_q ? ST_READ_DATA : ST_READ_ADD;
`endif
         end
      end else begin
         if (bit_cnt_q != FRAME_CNT) begin
            shreg_d   = shift_in[FRAME_W-2:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_CNT && !frame_bad_q) begin
               rx_data_d  = shift_in;
               rx_valid_d = 1'b1;
               if (state_q == ST_READ_ADD) rd_addr_seen_d = 1'b1;
            end
         end
`ifdef SPI_RD_ORDER_CHECK_EN
         if (bit_cnt_q == CNT_W'(1) && state_q != ST_WRITE) begin
            state_d = (op_w == OP_RD_DATA) ? ST_READ_DATA : ST_READ_ADD;
            if ((op_w == OP_RD_DATA && !rd_addr_seen_q) ||
                (op_w == OP_RD_ADDR &&  rd_addr_seen_q)) begin
               frame_bad_d = 1'b1;
               cmd_err_d   = 1'b1;
            end
         end
`endif
         // wait phase: frame complete, nothing sent yet for this frame
         if (state_q == ST_READ_DATA && bit_cnt_q == FRAME_CNT &&
             !tx_started_q && !frame_bad_q && tx_valid) begin
            ser_load     = 1'b1;
            tx_started_d = 1'b1;
         end
      end
      if (ser_done && !ser_abort) rd_addr_seen_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         bit_cnt_q      <= '0;
         shreg_q        <= '0;
         rd_addr_seen_q <= 1'b0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         tx_started_q   <= 1'b0;
         frame_bad_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         shreg_q        <= shreg_d;
         rd_addr_seen_q <= rd_addr_seen_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         tx_started_q   <= tx_started_d;
         frame_bad_q    <= frame_bad_d;
      end
   end

`ifdef SPI_RD_ORDER_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cmd_err_q <= 1'b0;
      else        cmd_err_q <= cmd_err_d;
   end
   assign cmd_err = cmd_err_q;
`else
   assign cmd_err = 1'b0;
`endif

   spi_tx_serializer #(
      .DATA_W (DATA_W)
   ) u_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (ser_load),
      .abort_i (ser_abort),
      .data_i  (tx_data),
      .miso_o  (MISO),
      .done_o  (ser_done)
   );

   assign rx_data            = rx_data_q;
   assign rx_valid           = rx_valid_q;
   assign dbg_state_o        = state_q;
   assign dbg_rd_addr_seen_o = rd_addr_seen_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_spi_ram_ctrl
//   Directed bench for spi_ram_ctrl. Inputs change and outputs are sampled
//   1 ns after each rising edge; rx_valid strobes are matched against exp_q
//   on the falling edge.
// ----------------------------------------------------------------------------
module tb_spi_ram_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       cmd_err;
   logic [2:0] dbg_state;
   logic       dbg_seen;

   int n_checks = 0;
   int n_errors = 0;

   logic [9:0] exp_q[$];

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd2;
   localparam logic [2:0] S_RADD  = 3'd3;
   localparam logic [2:0] S_RDAT  = 3'd4;

   spi_ram_ctrl dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .SS_n               (SS_n),
      .MOSI               (MOSI),
      .MISO               (MISO),
      .rx_data            (rx_data),
      .rx_valid           (rx_valid),
      .tx_data            (tx_data),
      .tx_valid           (tx_valid),
      .cmd_err            (cmd_err),
      .dbg_state_o        (dbg_state),
      .dbg_rd_addr_seen_o (dbg_seen)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drives SS_n low from IDLE, then n bits of frame MSB first
   task automatic send_bits(input logic [9:0] frame, input int n);
      SS_n = 1'b0;
      MOSI = frame[9];
      tick();
      for (int i = 9; i > 9 - n; i--) begin
         MOSI = frame[i];
         tick();
      end
   endtask

   task automatic end_frame();
      SS_n = 1'b1;
      MOSI = 1'b0;
      tick();
      check("idle_after_ss_high", dbg_state, S_IDLE);
   endtask

   task automatic expect_drained(input string tag);
      check(tag, exp_q.size(), 0);
   endtask

   // scoreboard: every strobe must match the next queued frame
   always @(negedge clk) begin
      if (rst_n && rx_valid) begin
         if (exp_q.size() == 0) check("spurious_rx_valid", rx_valid, 1'b0);
         else check("rx_data", rx_data, exp_q.pop_front());
      end
   end

   initial begin
      logic [7:0] pat;
      rst_n    = 1'b0;
      SS_n     = 1'b1;
      MOSI     = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      tick();
      tick();
      check("rst_state", dbg_state, S_IDLE);
      check("rst_rx_data", rx_data, 10'h000);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_miso", MISO, 1'b0);
      check("rst_cmd_err", cmd_err, 1'b0);
      check("rst_seen", dbg_seen, 1'b0);
      rst_n = 1'b1;
      tick();

      // 1: write address 00_1010_0101
      exp_q.push_back(10'h0A5);
      send_bits(10'h0A5, 10);
      check("t1_miso", MISO, 1'b0);
      tick();
      expect_drained("t1_strobe");
      end_frame();
      check("t1_rx_data_hold", rx_data, 10'h0A5);

      // 2: write data 01_0011_1100, extra bits and tx_valid ignored
      exp_q.push_back(10'h13C);
      send_bits(10'h13C, 10);
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         MOSI = 1'($urandom_range(0, 1));
         tick();
         check("t2_state_write", dbg_state, S_WRITE);
         check("t2_miso", MISO, 1'b0);
      end
      tx_valid = 1'b0;
      expect_drained("t2_strobe");
      end_frame();

      // 3: read address 10_0000_0111 then read data 11_0101_1010
      exp_q.push_back(10'h207);
      send_bits(10'h207, 10);
      tick();
      check("t3_state_radd", dbg_state, S_RADD);
      check("t3_seen_set", dbg_seen, 1'b1);
      end_frame();
      exp_q.push_back(10'h35A);
      send_bits(10'h35A, 10);
      check("t3_state_rdat", dbg_state, S_RDAT);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_wait_miso", MISO, 1'b0);
      end
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      check("t3_latch_miso", MISO, 1'b0);
      pat = 8'hC3;
      for (int i = 7; i >= 0; i--) begin
         tick();
         check("t3_miso_bit", MISO, pat[i]);
      end
      tick();
      check("t3_miso_after", MISO, 1'b0);
      check("t3_seen_clear", dbg_seen, 1'b0);
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      tick();
      tick();
      check("t3_late_tx_valid", MISO, 1'b0);
      tx_valid = 1'b0;
      expect_drained("t3_strobes");
      end_frame();

      // 4: abort after 6 bits, then a full frame
      send_bits(10'h0A5, 6);
      end_frame();
      exp_q.push_back(10'h1F0);
      send_bits(10'h1F0, 10);
      tick();
      expect_drained("t4_after_abort");
      end_frame();
      // abort on the 10th bit edge: no strobe
      send_bits(10'h13C, 9);
      MOSI = 1'b0;
      SS_n = 1'b1;
      tick();
      check("t4_abort_10th_state", dbg_state, S_IDLE);
      tick();
      check("t4_rx_data_kept", rx_data, 10'h1F0);
      // abort during read-data wait keeps rd_addr_seen
      exp_q.push_back(10'h2AA);
      send_bits(10'h2AA, 10);
      end_frame();
      exp_q.push_back(10'h3FF);
      send_bits(10'h3FF, 10);
      tick();
      end_frame();
      check("t4_seen_retained", dbg_seen, 1'b1);
      expect_drained("t4_strobes");

      // 5: reset in the middle of a read-data shift-out
      exp_q.push_back(10'h311);
      send_bits(10'h311, 10);
      check("t5_state_rdat", dbg_state, S_RDAT);
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tick();
      tick();
      check("t5_shifting", MISO, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_miso", MISO, 1'b0);
      check("t5_rst_rx_valid", rx_valid, 1'b0);
      check("t5_rst_seen", dbg_seen, 1'b0);
      check("t5_rst_state", dbg_state, S_IDLE);
      SS_n = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      expect_drained("t5_strobes");

      // 6: read-data frame 11_0000_0001 with no prior read address
`ifdef SPI_RD_ORDER_CHECK_EN
      send_bits(10'h301, 10);
      tick();
      check("t6_cmd_err", cmd_err, 1'b1);
      check("t6_seen", dbg_seen, 1'b0);
      end_frame();
      check("t6_cmd_err_sticky", cmd_err, 1'b1);
`else
      exp_q.push_back(10'h301);
      send_bits(10'h301, 10);
      tick();
      check("t6_state_radd", dbg_state, S_RADD);
      check("t6_seen", dbg_seen, 1'b1);
      check("t6_cmd_err", cmd_err, 1'b0);
      end_frame();
`endif
      expect_drained("t6_strobes");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
